// File: rtl/ex_alu_pipe.sv
// Dual-lane ALU execute stage: per-lane ALU / effective-address compute into a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_L_valid; lanes are fully independent.
// Backpressure: alu_ready_L = !skid.valid (register-driven, no path from out_L_ready); flush kills both lanes.
//
// Ports (L = 0,1):
//   clock, reset (async active-low), flush (sync kill of all lanes)
//   in_L_*       : op valid, isMem, rd, rdWen, src1, src2, op, memOp from the issue shaping stage
//   alu_ready_L  : lane L accepts an op this cycle
//   out_L_*      : valid/ready result toward memory/writeback, driven from the main register only
// Optional: define EX_ALU_PERF_EN to add perf_L_ops / perf_L_mem / perf_L_stall counters.

module ex_alu_lane #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            write_enable,
    input  logic            is_mem,
    input  logic [RD_W-1:0] rd,
    input  logic            rd_wen,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      op,
    input  logic [1:0]      mem_op,
    output logic            alu_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rd_wen,
    output logic            out_is_mem,
    output logic [1:0]      out_mem_op
`ifdef EX_ALU_PERF_EN
    ,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_mem,
    output logic [31:0]     perf_stall
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            rd_wen;
        logic            is_mem;
        logic [1:0]      mem_op;
    } entry_t;

    entry_t          m_q;
    entry_t          s_q;
    entry_t          new_d;
    logic            m_vld;
    logic            s_vld;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic            accept;
    logic            pop;

    assign shamt = src2[4:0];

    always_comb begin
        alu_res = '0;
        case (op)
            4'd0:    alu_res = src1 + src2;
            4'd1:    alu_res = src1 - src2;
            4'd2:    alu_res = src1 & src2;
            4'd3:    alu_res = src1 | src2;
            4'd4:    alu_res = src1 ^ src2;
            4'd5:    alu_res = src1 << shamt;
            4'd6:    alu_res = src1 >> shamt;
            4'd7:    alu_res = $signed(src1) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            default: alu_res = '0;
        endcase
        // Loads/stores always produce the effective address regardless of op.
        if (is_mem) begin
            alu_res = src1 + src2;
        end
    end

    always_comb begin
        new_d        = '0;
        new_d.result = alu_res;
        new_d.rd     = rd;
        new_d.rd_wen = rd_wen;
        new_d.is_mem = is_mem;
        new_d.mem_op = mem_op;
    end

    // Ready is the inverse of a flop, so upstream never sees a path from out_ready.
    assign alu_ready = ~s_vld;
    assign accept    = write_enable & ~s_vld & ~flush;
    assign pop       = m_vld & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q   <= '0;
            s_q   <= '0;
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (flush) begin
            // Payloads hold; only the valid bits are killed.
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (s_vld) begin
            // Skid full: no accept possible this cycle, only drain S into M.
            if (pop) begin
                m_q   <= s_q;
                s_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!m_vld || out_ready) begin
                m_q   <= new_d;
                m_vld <= 1'b1;
            end else begin
                s_q   <= new_d;
                s_vld <= 1'b1;
            end
        end else if (pop) begin
            m_vld <= 1'b0;
        end
    end

    assign out_valid  = m_vld;
    assign out_result = m_q.result;
    assign out_rd     = m_q.rd;
    assign out_rd_wen = m_q.rd_wen;
    assign out_is_mem = m_q.is_mem;
    assign out_mem_op = m_q.mem_op;

`ifdef EX_ALU_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_ops   <= '0;
            perf_mem   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (accept && is_mem) begin
                perf_mem <= perf_mem + 32'd1;
            end
            if (write_enable && s_vld) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

module ex_alu_pipe #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_0_writeEnable,
    input  logic            in_0_isMem,
    input  logic [RD_W-1:0] in_0_rd,
    input  logic            in_0_rdWen,
    input  logic [XLEN-1:0] in_0_src1,
    input  logic [XLEN-1:0] in_0_src2,
    input  logic [3:0]      in_0_op,
    input  logic [1:0]      in_0_memOp,
    input  logic            in_1_writeEnable,
    input  logic            in_1_isMem,
    input  logic [RD_W-1:0] in_1_rd,
    input  logic            in_1_rdWen,
    input  logic [XLEN-1:0] in_1_src1,
    input  logic [XLEN-1:0] in_1_src2,
    input  logic [3:0]      in_1_op,
    input  logic [1:0]      in_1_memOp,
    output logic            alu_ready_0,
    output logic            alu_ready_1,
    output logic            out_0_valid,
    input  logic            out_0_ready,
    output logic [XLEN-1:0] out_0_result,
    output logic [RD_W-1:0] out_0_rd,
    output logic            out_0_rdWen,
    output logic            out_0_isMem,
    output logic [1:0]      out_0_memOp,
    output logic            out_1_valid,
    input  logic            out_1_ready,
    output logic [XLEN-1:0] out_1_result,
    output logic [RD_W-1:0] out_1_rd,
    output logic            out_1_rdWen,
    output logic            out_1_isMem,
    output logic [1:0]      out_1_memOp
`ifdef EX_ALU_PERF_EN
    ,
    output logic [31:0]     perf_0_ops,
    output logic [31:0]     perf_0_mem,
    output logic [31:0]     perf_0_stall,
    output logic [31:0]     perf_1_ops,
    output logic [31:0]     perf_1_mem,
    output logic [31:0]     perf_1_stall
`endif
);

    ex_alu_lane #(.XLEN(XLEN), .RD_W(RD_W)) u_lane0 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .write_enable (in_0_writeEnable),
        .is_mem       (in_0_isMem),
        .rd           (in_0_rd),
        .rd_wen       (in_0_rdWen),
        .src1         (in_0_src1),
        .src2         (in_0_src2),
        .op           (in_0_op),
        .mem_op       (in_0_memOp),
        .alu_ready    (alu_ready_0),
        .out_valid    (out_0_valid),
        .out_ready    (out_0_ready),
        .out_result   (out_0_result),
        .out_rd       (out_0_rd),
        .out_rd_wen   (out_0_rdWen),
        .out_is_mem   (out_0_isMem),
        .out_mem_op   (out_0_memOp)
`ifdef EX_ALU_PERF_EN
        ,
        .perf_ops     (perf_0_ops),
        .perf_mem     (perf_0_mem),
        .perf_stall   (perf_0_stall)
`endif
    );

    ex_alu_lane #(.XLEN(XLEN), .RD_W(RD_W)) u_lane1 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .write_enable (in_1_writeEnable),
        .is_mem       (in_1_isMem),
        .rd           (in_1_rd),
        .rd_wen       (in_1_rdWen),
        .src1         (in_1_src1),
        .src2         (in_1_src2),
        .op           (in_1_op),
        .mem_op       (in_1_memOp),
        .alu_ready    (alu_ready_1),
        .out_valid    (out_1_valid),
        .out_ready    (out_1_ready),
        .out_result   (out_1_result),
        .out_rd       (out_1_rd),
        .out_rd_wen   (out_1_rdWen),
        .out_is_mem   (out_1_isMem),
        .out_mem_op   (out_1_memOp)
`ifdef EX_ALU_PERF_EN
        ,
        .perf_ops     (perf_1_ops),
        .perf_mem     (perf_1_mem),
        .perf_stall   (perf_1_stall)
`endif
    );

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Self-checking bench for ex_alu_pipe: directed vector table, skid/flush/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_ex_alu_pipe;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        we    [2];
    logic        mem   [2];
    logic        rdw   [2];
    logic        o_rdy [2];
    logic [4:0]  rd    [2];
    logic [31:0] s1    [2];
    logic [31:0] s2    [2];
    logic [3:0]  op    [2];
    logic [1:0]  mop   [2];
    logic        alu_rdy [2];
    logic        o_vld   [2];
    logic        o_rdw   [2];
    logic        o_mem   [2];
    logic [31:0] o_res   [2];
    logic [4:0]  o_rd    [2];
    logic [1:0]  o_mop   [2];
`ifdef EX_ALU_PERF_EN
    logic [31:0] perf_ops   [2];
    logic [31:0] perf_mem   [2];
    logic [31:0] perf_stall [2];
`endif

    ex_alu_pipe dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .in_0_writeEnable (we[0]),
        .in_0_isMem       (mem[0]),
        .in_0_rd          (rd[0]),
        .in_0_rdWen       (rdw[0]),
        .in_0_src1        (s1[0]),
        .in_0_src2        (s2[0]),
        .in_0_op          (op[0]),
        .in_0_memOp       (mop[0]),
        .in_1_writeEnable (we[1]),
        .in_1_isMem       (mem[1]),
        .in_1_rd          (rd[1]),
        .in_1_rdWen       (rdw[1]),
        .in_1_src1        (s1[1]),
        .in_1_src2        (s2[1]),
        .in_1_op          (op[1]),
        .in_1_memOp       (mop[1]),
        .alu_ready_0      (alu_rdy[0]),
        .alu_ready_1      (alu_rdy[1]),
        .out_0_valid      (o_vld[0]),
        .out_0_ready      (o_rdy[0]),
        .out_0_result     (o_res[0]),
        .out_0_rd         (o_rd[0]),
        .out_0_rdWen      (o_rdw[0]),
        .out_0_isMem      (o_mem[0]),
        .out_0_memOp      (o_mop[0]),
        .out_1_valid      (o_vld[1]),
        .out_1_ready      (o_rdy[1]),
        .out_1_result     (o_res[1]),
        .out_1_rd         (o_rd[1]),
        .out_1_rdWen      (o_rdw[1]),
        .out_1_isMem      (o_mem[1]),
        .out_1_memOp      (o_mop[1])
`ifdef EX_ALU_PERF_EN
        ,
        .perf_0_ops       (perf_ops[0]),
        .perf_0_mem       (perf_mem[0]),
        .perf_0_stall     (perf_stall[0]),
        .perf_1_ops       (perf_ops[1]),
        .perf_1_mem       (perf_mem[1]),
        .perf_1_stall     (perf_stall[1])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rdw;
        logic        mem;
        logic [1:0]  mop;
    } exp_t;

    typedef struct {
        int          lane;
        logic [3:0]  op;
        logic        mem;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mop;
        logic [31:0] exp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        last_out [2];
    logic [31:0] dut_log0[$];
    logic [31:0] m_ops   [2];
    logic [31:0] m_mem   [2];
    logic [31:0] m_stall [2];
    vec_t        vt [17];

    task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %0h want %0h (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    // Reference ALU written from the op table with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b, input logic f_mem);
        int     sh;
        longint sa;
        longint sb;
        sh = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f_mem) return a + b;
        case (f_op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int qsize(input int l);
        if (l == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic exp_t qfront(input int l);
        if (l == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int l = 0; l < 2; l++) begin
            last_out[l] = '0;
            m_ops[l]    = '0;
            m_mem[l]    = '0;
            m_stall[l]  = '0;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        int   n;
        for (int l = 0; l < 2; l++) begin
            n = qsize(l);
            if (n > 0) begin
                e = qfront(l);
                last_out[l] = e;
            end else begin
                e = last_out[l];
            end
            chk("alu_ready", l, 64'(alu_rdy[l]), 64'(n < 2));
            chk("out_valid", l, 64'(o_vld[l]), 64'(n > 0));
            chk("result", l, 64'(o_res[l]), 64'(e.res));
            chk("passthru", l, 64'({o_rd[l], o_rdw[l], o_mem[l], o_mop[l]}),
                64'({e.rd, e.rdw, e.mem, e.mop}));
`ifdef EX_ALU_PERF_EN
            chk("perf_ops", l, 64'(perf_ops[l]), 64'(m_ops[l]));
            chk("perf_mem", l, 64'(perf_mem[l]), 64'(m_mem[l]));
            chk("perf_stall", l, 64'(perf_stall[l]), 64'(m_stall[l]));
`endif
        end
    endtask

    // One clock: decide model transfers from pre-edge state, advance, then compare.
    task automatic cycle();
        bit   acc [2];
        bit   pop [2];
        exp_t item [2];
        for (int l = 0; l < 2; l++) begin
            acc[l] = we[l] && (qsize(l) < 2) && !flush;
            pop[l] = (qsize(l) > 0) && o_rdy[l];
            item[l].res = ref_alu(op[l], s1[l], s2[l], mem[l]);
            item[l].rd  = rd[l];
            item[l].rdw = rdw[l];
            item[l].mem = mem[l];
            item[l].mop = mop[l];
            if (acc[l]) m_ops[l] = m_ops[l] + 32'd1;
            if (acc[l] && mem[l]) m_mem[l] = m_mem[l] + 32'd1;
            if (we[l] && qsize(l) == 2) m_stall[l] = m_stall[l] + 32'd1;
        end
        if (o_vld[0] && o_rdy[0]) dut_log0.push_back(o_res[0]);
        @(posedge clock);
        #1;
        if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pop[0]) void'(q0.pop_front());
            if (pop[1]) void'(q1.pop_front());
            if (acc[0]) q0.push_back(item[0]);
            if (acc[1]) q1.push_back(item[1]);
        end
        check_outputs();
    endtask

    task automatic set_op(input int l, input logic [3:0] f_op, input logic [31:0] a, input logic [31:0] b);
        we[l]  = 1'b1;
        op[l]  = f_op;
        s1[l]  = a;
        s2[l]  = b;
        mem[l] = 1'b0;
        mop[l] = 2'd0;
        rd[l]  = 5'($urandom_range(0, 31));
        rdw[l] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 4'd0,  1'b0, 32'hFFFFFFFF, 32'h00000002, 2'd0, 32'h00000001};
        vt[1]  = '{1, 4'd7,  1'b0, 32'h80000000, 32'h00000024, 2'd0, 32'hF8000000};
        vt[2]  = '{1, 4'd9,  1'b0, 32'h00000001, 32'hFFFFFFFF, 2'd0, 32'h00000001};
        vt[3]  = '{1, 4'd12, 1'b0, 32'h00001234, 32'h00005678, 2'd0, 32'h00000000};
        vt[4]  = '{0, 4'd1,  1'b1, 32'h00001000, 32'h00000010, 2'd2, 32'h00001010};
        vt[5]  = '{0, 4'd1,  1'b0, 32'h00000000, 32'h00000001, 2'd0, 32'hFFFFFFFF};
        vt[6]  = '{1, 4'd8,  1'b0, 32'hFFFFFFFF, 32'h00000001, 2'd0, 32'h00000001};
        vt[7]  = '{1, 4'd8,  1'b0, 32'h00000001, 32'hFFFFFFFF, 2'd0, 32'h00000000};
        vt[8]  = '{0, 4'd5,  1'b0, 32'h00000001, 32'h0000003F, 2'd0, 32'h80000000};
        vt[9]  = '{0, 4'd6,  1'b0, 32'h80000000, 32'h0000001F, 2'd0, 32'h00000001};
        vt[10] = '{1, 4'd2,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'hF000F000};
        vt[11] = '{1, 4'd3,  1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 2'd0, 32'hFFFFF0F0};
        vt[12] = '{0, 4'd4,  1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 2'd0, 32'hF0F00F0F};
        vt[13] = '{0, 4'd15, 1'b0, 32'h12345678, 32'h9ABCDEF0, 2'd0, 32'h00000000};
        vt[14] = '{1, 4'd9,  1'b0, 32'hFFFFFFFF, 32'h00000001, 2'd0, 32'h00000000};
        vt[15] = '{0, 4'd7,  1'b0, 32'h7FFFFFFF, 32'h00000004, 2'd0, 32'h07FFFFFF};
        vt[16] = '{1, 4'd4,  1'b1, 32'hFFFFFFF0, 32'h00000020, 2'd3, 32'h00000010};

        reset = 1'b0;
        flush = 1'b0;
        for (int l = 0; l < 2; l++) begin
            we[l] = 1'b0; mem[l] = 1'b0; rdw[l] = 1'b0; o_rdy[l] = 1'b1;
            rd[l] = '0; s1[l] = '0; s2[l] = '0; op[l] = '0; mop[l] = '0;
        end
        model_reset();
        #12;
        check_outputs();
        #1;
        reset = 1'b1;

        // Directed vectors, one op per cycle, downstream always ready.
        for (int i = 0; i < 17; i++) begin
            int l;
            l = vt[i].lane;
            we[l]  = 1'b1;
            op[l]  = vt[i].op;
            mem[l] = vt[i].mem;
            s1[l]  = vt[i].a;
            s2[l]  = vt[i].b;
            mop[l] = vt[i].mop;
            rd[l]  = 5'(i);
            rdw[l] = (i % 2) == 1;
            cycle();
            we[l] = 1'b0;
            chk("vec_valid", l, 64'(o_vld[l]), 64'd1);
            chk("vec_result", l, 64'(o_res[l]), 64'(vt[i].exp));
            chk("vec_passthru", l, 64'({o_rd[l], o_rdw[l], o_mem[l], o_mop[l]}),
                64'({5'(i), (i % 2) == 1, vt[i].mem, vt[i].mop}));
        end
        cycle();

        // Lane0 stalled with A,B,C back to back while lane1 streams.
        dut_log0.delete();
        o_rdy[0] = 1'b0;
        o_rdy[1] = 1'b1;
        set_op(0, 4'd0, 32'd5, 32'd6);
        set_op(1, 4'd0, 32'd100, 32'd1);
        cycle();
        set_op(0, 4'd1, 32'd20, 32'd5);
        set_op(1, 4'd0, 32'd200, 32'd2);
        cycle();
        chk("skid_full_ready", 0, 64'(alu_rdy[0]), 64'd0);
        chk("lane1_flows", 1, 64'(o_res[1]), 64'd202);
        set_op(0, 4'd3, 32'h000000F0, 32'h0000000F);
        set_op(1, 4'd0, 32'd300, 32'd3);
        cycle();
        chk("held_c_ready", 0, 64'(alu_rdy[0]), 64'd0);
        chk("held_a_out", 0, 64'(o_res[0]), 64'd11);
        cycle();
        o_rdy[0] = 1'b1;
        cycle();
        cycle();
        we[0] = 1'b0;
        we[1] = 1'b0;
        cycle();
        cycle();
        chk("order_count", 0, 64'(dut_log0.size()), 64'd3);
        if (dut_log0.size() == 3) begin
            chk("order_a", 0, 64'(dut_log0[0]), 64'd11);
            chk("order_b", 0, 64'(dut_log0[1]), 64'd15);
            chk("order_c", 0, 64'(dut_log0[2]), 64'h000000FF);
        end

        // Fill both skids, then flush with a new op presented on both lanes.
        o_rdy[0] = 1'b0;
        o_rdy[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_op(0, 4'd0, 32'(k), 32'd1);
            set_op(1, 4'd4, 32'(k), 32'hFF);
            cycle();
        end
        chk("both_full0", 0, 64'(alu_rdy[0]), 64'd0);
        chk("both_full1", 1, 64'(alu_rdy[1]), 64'd0);
        o_rdy[0] = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid0", 0, 64'(o_vld[0]), 64'd0);
        chk("flush_valid1", 1, 64'(o_vld[1]), 64'd0);
        chk("flush_ready0", 0, 64'(alu_rdy[0]), 64'd1);
        chk("flush_ready1", 1, 64'(alu_rdy[1]), 64'd1);
        we[0] = 1'b0;
        we[1] = 1'b0;
        o_rdy[1] = 1'b1;
        cycle();
        chk("flush_dropped0", 0, 64'(o_vld[0]), 64'd0);
        chk("flush_dropped1", 1, 64'(o_vld[1]), 64'd0);

        // Asynchronous reset in the middle of a stall.
        o_rdy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_op(0, 4'd0, 32'h1000, 32'(k));
            cycle();
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 0, 64'(o_vld[0]), 64'd0);
        chk("arst_ready", 0, 64'(alu_rdy[0]), 64'd1);
        check_outputs();
        @(posedge clock);
        #1;
        check_outputs();
        we[0] = 1'b0;
        o_rdy[0] = 1'b1;
        #2;
        reset = 1'b1;
        cycle();

        // Randomized traffic; ops are held while their lane is not ready.
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < 2; l++) begin
                o_rdy[l] = ($urandom_range(0, 9) < 7);
                if (!(we[l] && qsize(l) == 2)) begin
                    we[l]  = ($urandom_range(0, 3) != 0);
                    op[l]  = 4'($urandom_range(0, 15));
                    mem[l] = ($urandom_range(0, 7) == 0);
                    case ($urandom_range(0, 3))
                        0:       s1[l] = 32'h80000000;
                        1:       s1[l] = 32'hFFFFFFFF;
                        default: s1[l] = $urandom;
                    endcase
                    s2[l]  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                    rd[l]  = 5'($urandom_range(0, 31));
                    rdw[l] = ($urandom_range(0, 1) == 1);
                    mop[l] = 2'($urandom_range(0, 3));
                end
            end
            cycle();
        end
        flush = 1'b0;
        we[0] = 1'b0;
        we[1] = 1'b0;
        o_rdy[0] = 1'b1;
        o_rdy[1] = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
